// File: rtl/md5_sched_if.sv
// Client and core bus bundle for md5_sched. The master modport is the
// scheduler side; the slave modport is the requesters plus md5 core side.
interface md5_sched_if #(
  parameter int N    = 4,
  parameter int ID_W = 2
);
  logic [N-1:0]       req_valid;
  logic [128*N-1:0]   req_data;
  logic [N-1:0]       req_ready;
  logic [N-1:0]       resp_valid;
  logic [N-1:0]       resp_ready;
  logic [127:0]       resp_data;
  logic               resp_err;
  logic [ID_W-1:0]    gnt_id;
  logic               busy;
  logic [127:0]       core_in;
  logic               core_in_valid;
  logic               core_ready;
  logic [127:0]       core_out;
  logic               core_out_valid;

  modport master (
    input  req_valid, req_data, resp_ready, core_ready, core_out, core_out_valid,
    output req_ready, resp_valid, resp_data, resp_err, gnt_id, busy,
           core_in, core_in_valid
  );

  modport slave (
    output req_valid, req_data, resp_ready, core_ready, core_out, core_out_valid,
    input  req_ready, resp_valid, resp_data, resp_err, gnt_id, busy,
           core_in, core_in_valid
  );
endinterface

// File: rtl/md5_sched.sv
// Round-robin scheduler sharing one md5 core among N requesters, one job in flight.
// Optional WAIT watchdog enabled by defining MD5_SCHED_TIMEOUT_EN.
module md5_sched #(
  parameter int N       = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 128
) (
  input logic         clk,
  input logic         rst_n,
  md5_sched_if.master bus
);
  localparam int NP = 2**ID_W;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [ID_W-1:0] r_rrPtr;
  logic [ID_W-1:0] r_gntId;
  logic [ID_W-1:0] w_winner;
  logic [ID_W-1:0] w_nextPtr;
  logic [127:0]    r_blk;
  logic [127:0]    r_res;
  logic [127:0]    w_winData;
  logic            r_err;
  logic            w_found;
  logic            w_respAccept;
  logic            w_timeout;
  logic [NP-1:0]   w_reqPad;
  logic [NP-1:0]   w_respReadyPad;

  assign w_reqPad       = NP'(bus.req_valid);
  assign w_respReadyPad = NP'(bus.resp_ready);
  assign w_respAccept   = (r_state == RESP) && w_respReadyPad[r_gntId];
  assign w_nextPtr      = (r_gntId == ID_W'(N - 1)) ? '0 : r_gntId + ID_W'(1);

  // Search starts at the round-robin pointer and wraps explicitly at N.
  always_comb begin
    int idx;
    idx      = 0;
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(r_rrPtr) + k;
      if (idx >= N) idx = idx - N;
      if (!w_found && w_reqPad[ID_W'(idx)]) begin
        w_found  = 1'b1;
        w_winner = ID_W'(idx);
      end
    end
  end

  always_comb begin
    w_winData = '0;
    for (int k = 0; k < N; k++) begin
      if (w_winner == ID_W'(k)) w_winData = bus.req_data[128*k +: 128];
    end
  end

`ifdef MD5_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_waitCnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_waitCnt <= '0;
    else if (r_state == WAIT)  r_waitCnt <= r_waitCnt + CW'(1);
    else                       r_waitCnt <= '0;
  end

  assign w_timeout    = (r_state == WAIT) && (r_waitCnt == CW'(TIMEOUT - 1));
  assign bus.resp_err = (r_state == RESP) && r_err;
`else
  logic w_unused;
  assign w_unused     = r_err | (TIMEOUT > 0);
  assign w_timeout    = 1'b0;
  assign bus.resp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_found) w_nextState = ISSUE;
      ISSUE:   if (bus.core_ready) w_nextState = WAIT;
      WAIT:    if (bus.core_out_valid || w_timeout) w_nextState = RESP;
      RESP:    if (w_respAccept) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rrPtr <= '0;
      r_gntId <= '0;
      r_blk   <= '0;
      r_res   <= '0;
      r_err   <= 1'b0;
    end else begin
      if (r_state == IDLE && w_found) begin
        r_blk   <= w_winData;
        r_gntId <= w_winner;
      end
      // A real result beats a watchdog expiry landing in the same cycle.
      if (r_state == WAIT) begin
        if (bus.core_out_valid) begin
          r_res <= bus.core_out;
          r_err <= 1'b0;
        end else if (w_timeout) begin
          r_res <= '0;
          r_err <= 1'b1;
        end
      end
      if (w_respAccept) r_rrPtr <= w_nextPtr;
    end
  end

  // req_ready is also gated by reset so every output reads 0 while rst_n is low.
  always_comb begin
    bus.req_ready  = '0;
    bus.resp_valid = '0;
    for (int k = 0; k < N; k++) begin
      bus.req_ready[k]  = rst_n && (r_state == IDLE) && w_found && (w_winner == ID_W'(k));
      bus.resp_valid[k] = (r_state == RESP) && (r_gntId == ID_W'(k));
    end
  end

  assign bus.core_in_valid = (r_state == ISSUE);
  assign bus.core_in       = (r_state == ISSUE) ? r_blk : '0;
  assign bus.resp_data     = r_res;
  assign bus.gnt_id        = r_gntId;
  assign bus.busy          = (r_state != IDLE);
endmodule

// File: tb/tb_md5_sched.sv
// Randomized self-checking bench for md5_sched with a behavioural md5 core stub
// and a round-robin reference model; timeout scenario under MD5_SCHED_TIMEOUT_EN.
module tb_md5_sched;
  localparam int N        = 4;
  localparam int ID_W     = 2;
  localparam int TIMEOUT  = 128;
  localparam int CORE_LAT = 66;
  localparam logic [127:0] PAT = {4{32'hA5A5A5A5}};

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int checkCount = 0;
  int errorCount = 0;
  int mRrPtr     = 0;

  logic         stubStall       = 1'b0;
  logic         stubNeverReturn = 1'b0;
  logic         stubBusy        = 1'b0;
  int           stubCnt         = 0;
  logic [127:0] stubData        = '0;

  md5_sched_if #(.N(N), .ID_W(ID_W)) bus ();

  md5_sched #(.N(N), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Core stub: accepts when idle, answers CORE_LAT cycles after accept for one cycle.
  initial begin
    logic         hs;
    logic [127:0] hsData;
    bus.core_ready     = 1'b1;
    bus.core_out       = '0;
    bus.core_out_valid = 1'b0;
    forever begin
      @(negedge clk);
      hs     = bus.core_in_valid && bus.core_ready;
      hsData = bus.core_in;
      @(posedge clk);
      #1;
      if (bus.core_out_valid) begin
        bus.core_out_valid = 1'b0;
        stubBusy           = 1'b0;
      end else if (stubBusy && !stubNeverReturn) begin
        stubCnt++;
        if (stubCnt == CORE_LAT) begin
          bus.core_out_valid = 1'b1;
          bus.core_out       = stubData;
        end
      end
      if (hs) begin
        stubBusy = 1'b1;
        stubCnt  = 0;
        stubData = hsData ^ PAT;
      end
      #1;
      bus.core_ready = !stubBusy && !stubStall;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [159:0] observed,
                             input logic [159:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] valid, input logic [N-1:0] rready);
    @(posedge clk);
    #1;
    bus.req_valid  = valid;
    bus.resp_ready = rready;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [N-1:0] oneHot(input int p);
    if (p < 0) return '0;
    return N'(1) << p;
  endfunction

  // Reference arbiter: first valid requester scanning from the pointer, modulo N.
  function automatic int modelWinner(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic waitGrant(output int c);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (bus.req_ready == '0 && c < 300);
  endtask

  task automatic waitResp(output int c);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (bus.resp_valid == '0 && c < 400);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mRrPtr = 0;
  endtask

  // mode 0: keep request valid with fresh data, 1: drop it, 2: fully randomized traffic.
  task automatic serveOne(input string tag, input int mode);
    int           c;
    int           exp;
    logic [127:0] expData;
    waitGrant(c);
    exp = modelWinner(bus.req_valid, mRrPtr);
    checkOutput({tag, "Grant"}, 160'(bus.req_ready), 160'(oneHot(exp)));
    if (exp < 0 || bus.req_ready == '0) return;
    expData = bus.req_data[128*exp +: 128] ^ PAT;
    @(posedge clk);
    #1;
    if (mode == 1) begin
      bus.req_valid[exp] = 1'b0;
    end else begin
      bus.req_data[128*exp +: 128] = rand128();
      if (mode == 2) begin
        bus.req_valid[exp] = 1'($urandom_range(0, 1));
        bus.resp_ready     = N'($urandom);
      end
    end
    waitResp(c);
    checkOutput({tag, "Valid"}, 160'(bus.resp_valid), 160'(oneHot(exp)));
    checkOutput({tag, "Gnt"},   160'(bus.gnt_id),     160'(exp));
    checkOutput({tag, "Data"},  160'(bus.resp_data),  160'(expData));
    checkOutput({tag, "Err"},   160'(bus.resp_err),   160'(0));
    for (int t = 0; t < 40 && !bus.resp_ready[exp]; t++) begin
      @(posedge clk);
      #1;
      bus.resp_ready = (t == 39) ? '1 : N'($urandom);
      @(negedge clk);
      checkOutput({tag, "Hold"}, 160'({bus.resp_valid, bus.resp_data}),
                  160'({oneHot(exp), expData}));
    end
    mRrPtr = (exp + 1) % N;
    if (mode == 2) begin
      @(posedge clk);
      #1;
      for (int p = 0; p < N; p++) begin
        if (!bus.req_valid[p] && $urandom_range(0, 1) == 1) begin
          bus.req_valid[p]           = 1'b1;
          bus.req_data[128*p +: 128] = rand128();
        end
      end
      if (bus.req_valid == '0) bus.req_valid[$urandom_range(0, N-1)] = 1'b1;
    end
  endtask

  initial begin
    int           c;
    int           lat;
    int           exp;
    int           strayBad;
    logic [127:0] d;
    logic [127:0] expData;

    bus.req_valid  = '1;
    bus.req_data   = '0;
    bus.resp_ready = '0;
    #2 rst_n = 1'b0;

    // Reset state with every requester asserting valid.
    repeat (3) @(negedge clk);
    checkOutput("rstReqReady",  160'(bus.req_ready),     160'(0));
    checkOutput("rstRespValid", 160'(bus.resp_valid),    160'(0));
    checkOutput("rstRespErr",   160'(bus.resp_err),      160'(0));
    checkOutput("rstCoreValid", 160'(bus.core_in_valid), 160'(0));
    checkOutput("rstCoreIn",    160'(bus.core_in),       160'(0));
    checkOutput("rstRespData",  160'(bus.resp_data),     160'(0));
    checkOutput("rstBusy",      160'(bus.busy),          160'(0));
    checkOutput("rstGntId",     160'(bus.gnt_id),        160'(0));
    @(posedge clk);
    #1;
    rst_n         = 1'b1;
    bus.req_valid = '0;

    // Single request on port 2 with latency check.
    d = 128'h0123456789ABCDEF0123456789ABCDEF;
    bus.req_data[128*2 +: 128] = d;
    applyStimulus(4'b0100, 4'hF);
    waitGrant(c);
    checkOutput("singleGrant", 160'(bus.req_ready), 160'(oneHot(modelWinner(4'b0100, mRrPtr))));
    applyStimulus(4'b0000, 4'hF);
    @(negedge clk);
    checkOutput("singleCoreValid", 160'(bus.core_in_valid), 160'(1));
    checkOutput("singleCoreIn",    160'(bus.core_in),       160'(d));
    checkOutput("singleReqReady",  160'(bus.req_ready),     160'(0));
    checkOutput("singleGntId",     160'(bus.gnt_id),        160'(2));
    waitResp(c);
    lat = 1 + c;
    checkOutput("singleLatency",   160'(lat),            160'(CORE_LAT + 3));
    checkOutput("singleRespValid", 160'(bus.resp_valid), 160'(4'b0100));
    checkOutput("singleRespData",  160'(bus.resp_data),  160'(d ^ PAT));
    checkOutput("singleRespErr",   160'(bus.resp_err),   160'(0));
    mRrPtr = 3;
    @(negedge clk);
    checkOutput("singleDone",      160'({bus.busy, bus.resp_valid}), 160'(0));
    checkOutput("singleDataKept",  160'(bus.resp_data),  160'(d ^ PAT));

    // Fairness: all requesters valid, grants rotate from port 0.
    doReset();
    for (int p = 0; p < N; p++) bus.req_data[128*p +: 128] = rand128();
    applyStimulus(4'hF, 4'hF);
    for (int j = 0; j < 5; j++) serveOne("fair", 0);
    applyStimulus(4'h0, 4'hF);

    // Backpressure on port 1, port 2 waiting behind it.
    doReset();
    bus.req_data[128*1 +: 128] = rand128();
    bus.req_data[128*2 +: 128] = rand128();
    applyStimulus(4'b0110, 4'b1101);
    waitGrant(c);
    exp = modelWinner(bus.req_valid, mRrPtr);
    checkOutput("bpGrant", 160'(bus.req_ready), 160'(oneHot(exp)));
    expData = bus.req_data[128*1 +: 128] ^ PAT;
    applyStimulus(4'b0100, 4'b1101);
    waitResp(c);
    checkOutput("bpRespValid", 160'(bus.resp_valid), 160'(4'b0010));
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      checkOutput("bpHold", 160'({bus.resp_valid, bus.req_ready, bus.core_in_valid, bus.resp_data}),
                  160'({4'b0010, 4'b0000, 1'b0, expData}));
    end
    bus.req_data[128*0 +: 128] = rand128();
    applyStimulus(4'b0101, 4'hF);
    mRrPtr = 2;
    serveOne("bpNext", 1);
    serveOne("bpTail", 1);

    // Core stall in ISSUE on port 3.
    d = rand128();
    bus.req_data[128*3 +: 128] = d;
    @(posedge clk);
    #1;
    stubStall     = 1'b1;
    bus.req_valid = 4'b1000;
    waitGrant(c);
    checkOutput("stallGrant", 160'(bus.req_ready), 160'(oneHot(modelWinner(bus.req_valid, mRrPtr))));
    applyStimulus(4'b0000, 4'hF);
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      checkOutput("stallIssue", 160'({bus.busy, bus.core_in_valid, bus.core_in}), 160'({2'b11, d}));
    end
    @(posedge clk);
    #1;
    stubStall = 1'b0;
    @(negedge clk);
    checkOutput("stallRelease", 160'({bus.core_ready, bus.core_in_valid}), 160'(2'b11));
    @(negedge clk);
    checkOutput("stallWait", 160'({bus.busy, bus.core_in_valid}), 160'(2'b10));
    waitResp(c);
    checkOutput("stallRespValid", 160'(bus.resp_valid), 160'(4'b1000));
    checkOutput("stallRespData",  160'(bus.resp_data),  160'(d ^ PAT));
    mRrPtr = 0;

    // Reset during WAIT abandons the job; the stray core result is ignored.
    bus.req_data[128*1 +: 128] = rand128();
    applyStimulus(4'b0010, 4'hF);
    serveOne("preRst", 1);
    bus.req_data[128*2 +: 128] = rand128();
    applyStimulus(4'b0100, 4'hF);
    waitGrant(c);
    checkOutput("rstJobGrant", 160'(bus.req_ready), 160'(oneHot(modelWinner(bus.req_valid, mRrPtr))));
    applyStimulus(4'b1001, 4'hF);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("asyncRst", 160'({bus.busy, bus.core_in_valid, bus.resp_valid, bus.req_ready, bus.gnt_id}),
                160'(0));
    @(posedge clk);
    #1;
    rst_n         = 1'b1;
    bus.req_valid = '0;
    mRrPtr        = 0;
    strayBad      = 0;
    for (int t = 0; t < 80; t++) begin
      @(negedge clk);
      if (bus.resp_valid != '0 || bus.busy) strayBad++;
    end
    checkOutput("strayResp", 160'(strayBad), 160'(0));
    bus.req_data[128*0 +: 128] = rand128();
    bus.req_data[128*3 +: 128] = rand128();
    applyStimulus(4'b1001, 4'hF);
    serveOne("postRst", 1);
    serveOne("postRstNext", 1);

    // Randomized traffic with random response backpressure.
    doReset();
    for (int p = 0; p < N; p++) bus.req_data[128*p +: 128] = rand128();
    applyStimulus(N'($urandom_range(1, (1 << N) - 1)), N'($urandom));
    for (int j = 0; j < 12; j++) serveOne("rnd", 2);
    applyStimulus(4'h0, 4'hF);

`ifdef MD5_SCHED_TIMEOUT_EN
    // Core never answers: watchdog returns an error response.
    repeat (80) @(negedge clk);
    stubNeverReturn = 1'b1;
    doReset();
    bus.req_data[128*0 +: 128] = rand128();
    applyStimulus(4'b0001, 4'hF);
    waitGrant(c);
    checkOutput("toGrant", 160'(bus.req_ready), 160'(4'b0001));
    applyStimulus(4'b0000, 4'hF);
    waitResp(c);
    lat = 1 + c;
    checkOutput("toLatency",   160'(lat),            160'(TIMEOUT + 2));
    checkOutput("toRespValid", 160'(bus.resp_valid), 160'(4'b0001));
    checkOutput("toRespErr",   160'(bus.resp_err),   160'(1));
    checkOutput("toRespData",  160'(bus.resp_data),  160'(0));
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end
endmodule
